ca90_im_gen_ctrl: RTL

- Sequencer that owns one combinational CA90 rule instance and a DIM-bit state register. It turns a seed into a stream of NUM_MAX_VEC-bounded item-memory hypervectors.
- Iterates CA90 for an optional warm-up, then emits one vector per accepted handshake, tagged with a write address.
- Sits between the configuration/CSR logic (start, seed, count) and the item-memory write port (valid/ready).

---
 rtl/ca90_im_gen_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ca90_im_gen_ctrl.sv
// CA90 item-memory generator: seeds a DIM-bit register, optionally warms it up,
// then streams ca90^k(seed) over a valid/ready port. Optional: CA90_ZERO_SEED_CHECK_EN.

module ca90_rule #(
    parameter int DIM = 8
) (
    input  logic [DIM-1:0] v,
    output logic [DIM-1:0] nxt
);
    for (genvar i = 0; i < DIM; i++) begin : g_bit
        assign nxt[i] = v[(i + DIM - 1) % DIM] ^ v[(i + 1) % DIM];
    end
endmodule

module ca90_im_gen_ctrl #(
    parameter int DIM         = 8,
    parameter int NUM_MAX_VEC = 256,
    parameter int WARMUP      = 0,
    localparam int ADDR_W     = $clog2(NUM_MAX_VEC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM-1:0]    seed,
    input  logic [ADDR_W:0]   num_vec,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DIM-1:0]    out_vec,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
`ifdef CA90_ZERO_SEED_CHECK_EN
    ,
    output logic              seed_err
`endif
);
    typedef enum logic [1:0] {IDLE, WARM, EMIT, DONE} state_t;

    localparam logic [ADDR_W:0] NUM_MAX   = (ADDR_W + 1)'(NUM_MAX_VEC);
    localparam logic [15:0]     WARM_LAST = 16'((WARMUP > 0) ? WARMUP - 1 : 0);

    state_t              state_q, state_d;
    logic [DIM-1:0]      vec_q, vec_d, vec_nxt;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W:0]     num_q, num_d, num_clamp;
    logic [15:0]         wcnt_q, wcnt_d;
    logic                seed_bad;

    ca90_rule #(.DIM(DIM)) u_rule (.v(vec_q), .nxt(vec_nxt));

    assign num_clamp = (num_vec > NUM_MAX) ? NUM_MAX : num_vec;

`ifdef CA90_ZERO_SEED_CHECK_EN
    // All-zeros is a CA90 fixed point, so such a run would be useless.
    assign seed_bad = (seed == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) seed_err <= 1'b0;
        else        seed_err <= (state_q == IDLE) && start && seed_bad;
    end
`else
    assign seed_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        idx_d   = idx_q;
        num_d   = num_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE: begin
                if (start && !seed_bad) begin
                    vec_d  = seed;
                    idx_d  = '0;
                    wcnt_d = '0;
                    num_d  = num_clamp;
                    if (num_clamp == '0) state_d = DONE;
                    else if (WARMUP > 0) state_d = WARM;
                    else                 state_d = EMIT;
                end
            end
            WARM: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    vec_d  = vec_nxt;
                    wcnt_d = wcnt_q + 16'd1;
                    if (wcnt_q == WARM_LAST) state_d = EMIT;
                end
            end
            EMIT: begin
                // abort wins over a same-cycle handshake; vec_q is left untouched
                if (abort) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    vec_d = vec_nxt;
                    idx_d = idx_q + ADDR_W'(1);
                    if ({1'b0, idx_q} == num_q - (ADDR_W + 1)'(1)) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            idx_q   <= '0;
            num_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign out_valid = (state_q == EMIT);
    assign out_vec   = vec_q;
    assign out_addr  = idx_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
endmodule
